// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (ALU) -> RESP (hold).
// Build option: define ALU_ARB_RR_EN for round-robin arbitration under contention;
// left undefined, requester 0 has fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic [9:0]  req_shamt,
  input  logic [11:0] req_funct,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned FW = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [FW-1:0] F_ADDU = 6'b001001;
  localparam logic [FW-1:0] F_SUBU = 6'b001010;
  localparam logic [FW-1:0] F_NOR  = 6'b010011;
  localparam logic [FW-1:0] F_SLTU = 6'b101010;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          owner;
  logic          accept;
  logic          gidx;
  logic          funct_ok;
  logic [DW-1:0] sel_src1;
  logic [DW-1:0] sel_src2;
  logic [SW-1:0] sel_shamt;
  logic [FW-1:0] sel_funct;

`ifdef ALU_ARB_RR_EN
  logic last;

  // Under contention the requester not granted last wins
  always_comb begin
    gidx = req_valid[1];
    if (&req_valid) gidx = ~last;
  end

  // Last-granted pointer; reset value 1 makes the first contention go to requester 0
  always_ff @(posedge clk) begin
    if (!rst_n) last <= 1'b1;
    else if (accept) last <= gidx;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid
  always_comb begin
    gidx = ~req_valid[0];
  end
`endif

  // Acceptance handshake and operand mux for the granted requester
  always_comb begin
    accept    = (state == IDLE) && (|req_valid);
    req_ready = 2'b00;
    if (accept) req_ready = gidx ? 2'b10 : 2'b01;
    sel_src1  = gidx ? req_src1[63:32] : req_src1[31:0];
    sel_src2  = gidx ? req_src2[63:32] : req_src2[31:0];
    sel_shamt = gidx ? req_shamt[9:5]  : req_shamt[4:0];
    sel_funct = gidx ? req_funct[11:6] : req_funct[5:0];
  end

  // Supported-funct decode on the operation currently at the ALU
  always_comb begin
    funct_ok = 1'b0;
    case (alu_funct)
      F_ADDU, F_SUBU, F_NOR, F_SLTU: funct_ok = 1'b1;
      default:                       funct_ok = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ALU operand registers: loaded on acceptance, so non-zero only during EXEC
  always_ff @(posedge clk) begin
    if (!rst_n || !accept) begin
      alu_src1  <= '0;
      alu_src2  <= '0;
      alu_shamt <= '0;
      alu_funct <= '0;
    end else begin
      alu_src1  <= sel_src1;
      alu_src2  <= sel_src2;
      alu_shamt <= sel_shamt;
      alu_funct <= sel_funct;
    end
  end

  // Owner of the in-flight operation
  always_ff @(posedge clk) begin
    if (!rst_n)      owner <= 1'b0;
    else if (accept) owner <= gidx;
  end

  // Response capture at the end of EXEC, held until the owner consumes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid  <= owner ? 2'b10 : 2'b01;
      rsp_result <= funct_ok ? alu_result : DW'(0);
      rsp_err    <= ~funct_ok;
    end else if ((state == RESP) && rsp_ready[owner]) begin
      rsp_valid  <= 2'b00;
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these ports, one per entry (name  direction  width  meaning):
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  bit i set: requester i presents an operation.
REQ-005 req_ready  output  2  bit i set: requester i operation accepted this cycle.
REQ-006 req_src1  input  64  {req1 Src1, req0 Src1}, 32 bits each.
REQ-007 req_src2  input  64  {req1 Src2, req0 Src2}.
REQ-008 req_shamt  input  10  {req1 shamt, req0 shamt}, 5 bits each.
REQ-009 req_funct  input  12  {req1 funct, req0 funct}, 6 bits each.
REQ-010 rsp_valid  output  2  bit i set: response for requester i held.
REQ-011 rsp_ready  input  2  bit i set: requester i consumes its response.
REQ-012 rsp_result  output  32  result of the completed operation.
REQ-013 rsp_err  output  1  completed operation had an unsupported funct.
REQ-014 alu_src1 / alu_src2  output  32 each  operands to the shared ALU.
REQ-015 alu_shamt  output  5; alu_funct  output  6  shamt and funct to the ALU.
REQ-016 alu_result  input  32  combinational result from the ALU.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 In IDLE with any req_valid bit set, the block SHALL select a requester g, assert only req_ready[g] that cycle, register its src1/src2/shamt/funct and owner g, go to EXEC.
REQ-019 req_ready SHALL be 2'b00 in EXEC and RESP, and in IDLE with req_valid==2'b00.
REQ-020 In EXEC, alu_* outputs SHALL drive the registered operands; rsp_result SHALL capture alu_result at the end of that cycle; the FSM SHALL go to RESP.
REQ-021 Outside EXEC, alu_* outputs SHALL be all zero (alu_funct=6'b000000).
REQ-022 Supported funct: 6'b001001 addu, 6'b001010 subu, 6'b010011 nor, 6'b101010 sltu; any other funct SHALL give rsp_result=0 and rsp_err=1, with the EXEC cycle still spent.
REQ-023 In RESP, rsp_valid[g] SHALL be 1, the other bit 0; rsp_result and rsp_err SHALL stay stable until rsp_ready[g]=1, then the FSM SHALL return to IDLE.
REQ-024 rsp_ready on the non-owner bit SHALL be ignored.
REQ-025 Latency: acceptance in cycle T SHALL give rsp_valid in cycle T+2; next acceptance no earlier than the cycle after the response handshake.
REQ-026 Requests arriving during EXEC/RESP SHALL wait; req_valid dropped before acceptance is permitted and SHALL leave no state.

Reset
REQ-027 With rst_n=0 at a clock edge: state IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, alu_* outputs=0, round-robin pointer=last-granted 1.
REQ-028 Reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: with both req_valid bits set, the requester not granted last SHALL win; pointer updates on every acceptance; first contention after reset grants requester 0.
REQ-030 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention; no pointer state.

Verification
REQ-031 Single addu: req0 src1=5, src2=7, funct=6'b001001 -> req_ready=2'b01 at T, rsp_valid=2'b01 at T+2, rsp_result=12, rsp_err=0.
REQ-032 Sltu/subu: req1 src1=3, src2=32'hFFFFFFFF sltu -> result 1; src1=0, src2=1 subu -> 32'hFFFFFFFF.
REQ-033 Illegal funct 6'b000000 on req0 -> rsp_result=0, rsp_err=1, alu_funct never nonzero-invalid outside EXEC.
REQ-034 Both requesters valid continuously, 4 operations -> with ALU_ARB_RR_EN grant order 0,1,0,1; without it 0,0,0,0 while req0 stays valid.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result, rsp_err constant, req_ready=0 throughout; handshake then IDLE.
REQ-036 Assert rst_n=0 during EXEC and during RESP -> next cycle all outputs zero, no response ever issued for the killed operation.
